// File: rtl/i2c_bus_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// i2c_arb_pkg
// Shared types and defaults for the I2C bus arbiter and its condition detector.
//   arb_state_t          : arbiter FSM state encoding
//   owner_t              : which inner engine currently owns the pins/FIFOs
//   I2C_BUS_FREE_CYCLES  : default bus-free hold-off length after STOP
// -----------------------------------------------------------------------------
package i2c_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    MASTER,
    SLAVE,
    HOLDOFF
  } arb_state_t;

  typedef enum logic {
    OWN_SLAVE,
    OWN_MASTER
  } owner_t;

  localparam int I2C_BUS_FREE_CYCLES = 16;

endpackage

// File: rtl/i2c_bus_arbiter_if.sv
// -----------------------------------------------------------------------------
// i2c_bus_arbiter_if
// Bundles the synchronized bus lines, both inner-engine output sets and the
// granted (muxed) outputs of the I2C bus arbiter.
//   modport master : arbiter view (engine signals in, granted signals out)
//   modport slave  : surrounding peripheral view (the reverse direction)
// -----------------------------------------------------------------------------
interface i2c_bus_arbiter_if;

  // Role request and bus lines
  logic       ms_select;
  logic       SDA_sync;
  logic       SCL_sync;

  // Master inner engine outputs
  logic       SDA_out_master;
  logic       SCL_out_master;
  logic       TX_read_enable_master;
  logic       RX_write_enable_master;
  logic       set_transaction_complete_master;
  logic       ack_error_set_master;
  logic [7:0] rx_data_master;

  // Slave inner engine outputs
  logic       SDA_out_slave;
  logic       SCL_out_slave;
  logic       TX_read_enable_slave;
  logic       RX_write_enable_slave;
  logic       set_transaction_complete_slave;
  logic       ack_error_set_slave;
  logic [7:0] rx_data_slave;

  // Arbiter outputs
  logic       master_enable;
  logic       slave_enable;
  logic       SDA_out;
  logic       SCL_out;
  logic       TX_read_enable;
  logic       RX_write_enable;
  logic       set_transaction_complete;
  logic       ack_error_set;
  logic [7:0] rx_data;
  logic       bus_busy;
  logic       arbitration_lost;

  modport master (
    input  ms_select, SDA_sync, SCL_sync,
    input  SDA_out_master, SCL_out_master, TX_read_enable_master,
           RX_write_enable_master, set_transaction_complete_master,
           ack_error_set_master, rx_data_master,
    input  SDA_out_slave, SCL_out_slave, TX_read_enable_slave,
           RX_write_enable_slave, set_transaction_complete_slave,
           ack_error_set_slave, rx_data_slave,
    output master_enable, slave_enable, SDA_out, SCL_out, TX_read_enable,
           RX_write_enable, set_transaction_complete, ack_error_set,
           rx_data, bus_busy, arbitration_lost
  );

  modport slave (
    output ms_select, SDA_sync, SCL_sync,
    output SDA_out_master, SCL_out_master, TX_read_enable_master,
           RX_write_enable_master, set_transaction_complete_master,
           ack_error_set_master, rx_data_master,
    output SDA_out_slave, SCL_out_slave, TX_read_enable_slave,
           RX_write_enable_slave, set_transaction_complete_slave,
           ack_error_set_slave, rx_data_slave,
    input  master_enable, slave_enable, SDA_out, SCL_out, TX_read_enable,
           RX_write_enable, set_transaction_complete, ack_error_set,
           rx_data, bus_busy, arbitration_lost
  );

endinterface

// File: rtl/i2c_bus_condition_detect.sv
// -----------------------------------------------------------------------------
// i2c_bus_condition_detect
// Registers the previous SDA/SCL samples and flags START, STOP and SCL rising
// edges. Reusable by the inner master/slave engines.
//   clk, rst           : clock, asynchronous active-high reset
//   sda_sync, scl_sync : synchronized bus lines
//   start, stop        : bus condition seen on this sample (combinational)
//   scl_rise           : SCL went low->high on this sample (combinational)
// -----------------------------------------------------------------------------
module i2c_bus_condition_detect (
  input  logic clk,
  input  logic rst,
  input  logic sda_sync,
  input  logic scl_sync,
  output logic start,
  output logic stop,
  output logic scl_rise
);

  logic sda_p_q, sda_p_d;
  logic scl_p_q, scl_p_d;

  always_comb begin
    sda_p_d = sda_sync;
    scl_p_d = scl_sync;
  end

  // Previous samples reset high so a bus idling high never looks like a START.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sda_p_q <= 1'b1;
      scl_p_q <= 1'b1;
    end else begin
      sda_p_q <= sda_p_d;
      scl_p_q <= scl_p_d;
    end
  end

  assign start    = scl_sync & scl_p_q & sda_p_q & ~sda_sync;
  assign stop     = scl_sync & scl_p_q & ~sda_p_q & sda_sync;
  assign scl_rise = scl_sync & ~scl_p_q;

endmodule

// File: rtl/i2c_bus_arbiter.sv
// -----------------------------------------------------------------------------
// i2c_bus_arbiter
// Grants the shared I2C pins and FIFO ports to either the master or the slave
// inner engine, tracks bus-busy from START/STOP, enforces a bus-free hold-off
// after STOP and (optionally) detects multi-master arbitration loss.
//   clk    : system clock
//   n_rst  : asynchronous reset, active-high (1 = reset)
//   bus    : i2c_bus_arbiter_if.master -- role request, bus lines, both engine
//            output sets in; enables, granted pin drive / FIFO strobes /
//            rx_data, bus_busy and arbitration_lost out
// Parameter BUS_FREE_CYCLES: high cycles required after STOP before IDLE (>=1).
// Build option: define I2C_ARB_LOSS_EN to enable arbitration-loss detection;
// otherwise MASTER is left only on STOP and arbitration_lost stays 0.
// -----------------------------------------------------------------------------
module i2c_bus_arbiter
  import i2c_arb_pkg::*;
#(
  parameter int BUS_FREE_CYCLES = I2C_BUS_FREE_CYCLES
) (
  input  logic              clk,
  input  logic              n_rst,
  i2c_bus_arbiter_if.master bus
);

  localparam int                CNT_W    = $clog2(BUS_FREE_CYCLES + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(BUS_FREE_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(BUS_FREE_CYCLES);

  logic start, stop, scl_rise;
  logic lines_high;
  logic loss;

  arb_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  owner_t           owner;

  logic       sda_out_q, sda_out_d;
  logic       scl_out_q, scl_out_d;
  logic       tx_rd_q, tx_rd_d;
  logic       rx_wr_q, rx_wr_d;
  logic       txn_done_q, txn_done_d;
  logic       ack_err_q, ack_err_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       arb_lost_q, arb_lost_d;

  i2c_bus_condition_detect u_cond (
    .clk      (clk),
    .rst      (n_rst),
    .sda_sync (bus.SDA_sync),
    .scl_sync (bus.SCL_sync),
    .start    (start),
    .stop     (stop),
    .scl_rise (scl_rise)
  );

  assign lines_high = bus.SDA_sync & bus.SCL_sync;

`ifdef I2C_ARB_LOSS_EN
  // We released SDA but someone else pulled it low as SCL rose: we lost.
  assign loss = scl_rise & bus.SDA_out_master & ~bus.SDA_sync;
`else
  logic loss_unused;
  assign loss        = 1'b0;
  assign loss_unused = scl_rise;
`endif

  // Next-state, hold-off counter and arbitration-loss pulse
  always_comb begin
    state_d    = state_q;
    cnt_d      = '0;
    arb_lost_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (start)                             state_d = SLAVE;
        else if (bus.ms_select && lines_high)  state_d = MASTER;
      end
      MASTER: begin
        if (stop) begin
          state_d = HOLDOFF;
        end else if (loss) begin
          state_d    = SLAVE;
          arb_lost_d = 1'b1;
        end
      end
      SLAVE: begin
        if (stop) state_d = HOLDOFF;
      end
      HOLDOFF: begin
        // Counter restarts whenever either line dips and saturates at the top.
        if (start) begin
          state_d = SLAVE;
        end else if (lines_high && (cnt_q == CNT_LAST)) begin
          state_d = IDLE;
        end else if (lines_high) begin
          cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign owner = (state_q == MASTER) ? OWN_MASTER : OWN_SLAVE;

  // Output mux follows the owner of the current state, registered below.
  always_comb begin
    sda_out_d  = bus.SDA_out_slave;
    scl_out_d  = bus.SCL_out_slave;
    tx_rd_d    = bus.TX_read_enable_slave;
    rx_wr_d    = bus.RX_write_enable_slave;
    txn_done_d = bus.set_transaction_complete_slave;
    ack_err_d  = bus.ack_error_set_slave;
    rx_data_d  = bus.rx_data_slave;
    if (owner == OWN_MASTER) begin
      sda_out_d  = bus.SDA_out_master;
      scl_out_d  = bus.SCL_out_master;
      tx_rd_d    = bus.TX_read_enable_master;
      rx_wr_d    = bus.RX_write_enable_master;
      txn_done_d = bus.set_transaction_complete_master;
      ack_err_d  = bus.ack_error_set_master;
      rx_data_d  = bus.rx_data_master;
    end
  end

  always_ff @(posedge clk or posedge n_rst) begin
    if (n_rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      sda_out_q  <= 1'b1;
      scl_out_q  <= 1'b1;
      tx_rd_q    <= 1'b0;
      rx_wr_q    <= 1'b0;
      txn_done_q <= 1'b0;
      ack_err_q  <= 1'b0;
      rx_data_q  <= 8'h00;
      arb_lost_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      sda_out_q  <= sda_out_d;
      scl_out_q  <= scl_out_d;
      tx_rd_q    <= tx_rd_d;
      rx_wr_q    <= rx_wr_d;
      txn_done_q <= txn_done_d;
      ack_err_q  <= ack_err_d;
      rx_data_q  <= rx_data_d;
      arb_lost_q <= arb_lost_d;
    end
  end

  assign bus.master_enable            = (state_q == MASTER);
  assign bus.slave_enable             = (state_q != MASTER);
  assign bus.bus_busy                 = (state_q != IDLE);
  assign bus.SDA_out                  = sda_out_q;
  assign bus.SCL_out                  = scl_out_q;
  assign bus.TX_read_enable           = tx_rd_q;
  assign bus.RX_write_enable          = rx_wr_q;
  assign bus.set_transaction_complete = txn_done_q;
  assign bus.ack_error_set            = ack_err_q;
  assign bus.rx_data                  = rx_data_q;
  assign bus.arbitration_lost         = arb_lost_q;

endmodule

// File: tb/tb_i2c_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_i2c_bus_arbiter
// Directed self-checking bench for i2c_bus_arbiter (BUS_FREE_CYCLES = 16).
// Expectations for the arbitration-loss step follow I2C_ARB_LOSS_EN.
// -----------------------------------------------------------------------------
module tb_i2c_bus_arbiter;

`ifdef I2C_ARB_LOSS_EN
  localparam bit LOSS_EN = 1'b1;
`else
  localparam bit LOSS_EN = 1'b0;
`endif

  logic clk;
  logic rst;
  int   n_chk;
  int   n_pass;
  int   n_fail;

  i2c_bus_arbiter_if bus ();

  i2c_bus_arbiter #(.BUS_FREE_CYCLES(16)) dut (
    .clk   (clk),
    .n_rst (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [7:0] addr;
    n_chk  = 0;
    n_pass = 0;
    n_fail = 0;
    addr   = 8'h0E;

    rst = 1'b1;
    bus.ms_select = 1'b0;
    bus.SDA_sync  = 1'b1;
    bus.SCL_sync  = 1'b1;
    bus.SDA_out_master = 1'b1;  bus.SCL_out_master = 1'b1;
    bus.TX_read_enable_master = 1'b0;  bus.RX_write_enable_master = 1'b0;
    bus.set_transaction_complete_master = 1'b0;  bus.ack_error_set_master = 1'b0;
    bus.rx_data_master = 8'hA5;
    bus.SDA_out_slave = 1'b1;  bus.SCL_out_slave = 1'b1;
    bus.TX_read_enable_slave = 1'b0;  bus.RX_write_enable_slave = 1'b0;
    bus.set_transaction_complete_slave = 1'b0;  bus.ack_error_set_slave = 1'b0;
    bus.rx_data_slave = 8'h00;

    // Reset values
    repeat (2) tick();
    chk("rst_sda_out", bus.SDA_out, 1);
    chk("rst_scl_out", bus.SCL_out, 1);
    chk("rst_busy", bus.bus_busy, 0);
    chk("rst_slave_en", bus.slave_enable, 1);
    chk("rst_master_en", bus.master_enable, 0);
    chk("rst_arb_lost", bus.arbitration_lost, 0);
    chk("rst_rx_data", bus.rx_data, 8'h00);
    rst = 1'b0;
    repeat (2) tick();
    chk("idle_busy", bus.bus_busy, 0);
    chk("idle_master_en", bus.master_enable, 0);

    // Master grant, output latency, STOP and 16-cycle hold-off
    bus.ms_select = 1'b1;
    bus.SDA_out_master = 1'b0;
    tick();
    chk("m_master_en", bus.master_enable, 1);
    chk("m_busy", bus.bus_busy, 1);
    chk("m_sda_prev_owner", bus.SDA_out, 1);
    bus.ms_select = 1'b0;
    tick();
    chk("m_sda_follow", bus.SDA_out, 0);
    chk("m_ignore_sel", bus.master_enable, 1);
    bus.ack_error_set_master = 1'b1;
    bus.TX_read_enable_slave = 1'b1;
    bus.SDA_sync = 1'b0;
    tick();
    chk("m_start_ignored", bus.master_enable, 1);
    chk("m_ack_mux", bus.ack_error_set, 1);
    chk("m_txrd_mux", bus.TX_read_enable, 0);
    bus.ack_error_set_master = 1'b0;
    bus.TX_read_enable_slave = 1'b0;
    bus.SDA_sync = 1'b1;
    tick();
    chk("stop_master_en", bus.master_enable, 0);
    chk("stop_busy", bus.bus_busy, 1);
    repeat (15) tick();
    chk("hold15_busy", bus.bus_busy, 1);
    chk("hold_sda_slave", bus.SDA_out, 1);
    tick();
    chk("hold16_free", bus.bus_busy, 0);
    bus.SDA_out_master = 1'b1;

    // External START and address byte 0x0E to the slave
    bus.SDA_sync = 1'b0;
    tick();
    chk("s_busy", bus.bus_busy, 1);
    chk("s_master_en", bus.master_enable, 0);
    for (int i = 7; i >= 0; i--) begin
      bus.SCL_sync = 1'b0;  tick();
      bus.SDA_sync = addr[i];  tick();
      bus.SCL_sync = 1'b1;  tick();
      tick();
    end
    chk("s_after_byte_busy", bus.bus_busy, 1);
    bus.rx_data_slave = 8'h0E;
    bus.RX_write_enable_slave = 1'b1;
    #1;
    chk("s_rxwr_latency", bus.RX_write_enable, 0);
    tick();
    chk("s_rx_data", bus.rx_data, 8'h0E);
    chk("s_rxwr", bus.RX_write_enable, 1);
    bus.RX_write_enable_slave = 1'b0;
    tick();
    chk("s_rxwr_drop", bus.RX_write_enable, 0);

    // STOP, START after 5 high cycles in HOLDOFF abandons the hold-off
    bus.SDA_sync = 1'b1;
    tick();
    repeat (5) tick();
    chk("ho_busy", bus.bus_busy, 1);
    bus.SDA_sync = 1'b0;
    tick();
    chk("ho_start_busy", bus.bus_busy, 1);
    chk("ho_start_slave_en", bus.slave_enable, 1);
    bus.SCL_sync = 1'b0;  tick();
    bus.SDA_sync = 1'b1;  tick();
    bus.SCL_sync = 1'b1;  tick();
    repeat (20) tick();
    chk("ho_abandoned_busy", bus.bus_busy, 1);
    bus.SCL_sync = 1'b0;  tick();
    bus.SDA_sync = 1'b0;  tick();
    bus.SCL_sync = 1'b1;  tick();
    bus.SDA_sync = 1'b1;  tick();
    repeat (16) tick();
    chk("ho_free", bus.bus_busy, 0);

    // START beats ms_select in IDLE
    bus.ms_select = 1'b1;
    bus.SDA_sync = 1'b0;
    tick();
    chk("prio_master_en", bus.master_enable, 0);
    chk("prio_busy", bus.bus_busy, 1);
    bus.ms_select = 1'b0;
    bus.SDA_sync = 1'b1;
    tick();
    repeat (16) tick();
    chk("prio_free", bus.bus_busy, 0);

    // Arbitration loss
    bus.ms_select = 1'b1;
    tick();
    chk("al_master_en", bus.master_enable, 1);
    bus.ms_select = 1'b0;
    bus.SDA_out_master = 1'b1;
    bus.SDA_out_slave = 1'b0;
    bus.SCL_sync = 1'b0;  tick();
    bus.SDA_sync = 1'b0;  tick();
    bus.SCL_sync = 1'b1;  tick();
    chk("al_pulse", bus.arbitration_lost, LOSS_EN);
    chk("al_master_en_after", bus.master_enable, !LOSS_EN);
    chk("al_sda_still_master", bus.SDA_out, 1);
    tick();
    chk("al_pulse_end", bus.arbitration_lost, 0);
    chk("al_sda_owner", bus.SDA_out, LOSS_EN ? 8'd0 : 8'd1);
    chk("al_state_hold", bus.master_enable, !LOSS_EN);
    bus.SDA_sync = 1'b1;
    tick();
    bus.SDA_out_slave = 1'b1;
    repeat (16) tick();
    chk("al_free", bus.bus_busy, 0);

    // Asynchronous reset mid-byte in MASTER
    bus.ms_select = 1'b1;
    tick();
    chk("r_master_en", bus.master_enable, 1);
    bus.SDA_out_master = 1'b0;
    bus.SCL_out_master = 1'b0;
    bus.SCL_sync = 1'b0;
    tick();
    chk("r_sda_drive", bus.SDA_out, 0);
    chk("r_scl_drive", bus.SCL_out, 0);
    #3;
    rst = 1'b1;
    #1;
    chk("r_async_sda", bus.SDA_out, 1);
    chk("r_async_scl", bus.SCL_out, 1);
    chk("r_async_master_en", bus.master_enable, 0);
    chk("r_async_busy", bus.bus_busy, 0);
    bus.SCL_sync = 1'b1;
    tick();
    rst = 1'b0;
    chk("r_release_busy", bus.bus_busy, 0);
    tick();
    chk("r_regrant", bus.master_enable, 1);
    bus.ms_select = 1'b0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/i2c_bus_arbiter.md
# i2c_bus_arbiter

Owns the shared I2C pins and FIFO ports for the APB I2C peripheral. It grants the bus either to the master inner engine or to `slave_inner`, and muxes the granted engine's SDA/SCL drive, FIFO enables and status pulses to the top level. It tracks bus-busy from START/STOP conditions and enforces a bus-free hold-off after STOP. It also detects multi-master arbitration loss and hands control to the slave engine when loss occurs.

## Interface
Parameters:
- BUS_FREE_CYCLES, 16: clk cycles SDA and SCL must both be high after STOP before the bus is treated as free (≥1).

Ports:
- clk  in  1  system clock
- n_rst  in  1  reset, asynchronous, active-high (1 = reset)
- ms_select  in  1  requested role: 1 = master, 0 = slave. Only sampled in IDLE.
- SDA_sync, SCL_sync  in  1 each  synchronized bus lines
- SDA_out_master, SCL_out_master, TX_read_enable_master, RX_write_enable_master, set_transaction_complete_master, ack_error_set_master  in  1 each  master engine outputs
- rx_data_master  in  8  master received byte
- SDA_out_slave, SCL_out_slave, TX_read_enable_slave, RX_write_enable_slave, set_transaction_complete_slave, ack_error_set_slave  in  1 each  slave engine outputs
- rx_data_slave  in  8  slave received byte
- master_enable  out  1  master engine allowed to run; held in reset when 0
- slave_enable  out  1  slave engine allowed to run
- SDA_out, SCL_out  out  1 each  pin drive (1 = release)
- TX_read_enable, RX_write_enable, set_transaction_complete, ack_error_set  out  1 each  granted engine's signals
- rx_data  out  8  granted engine's byte
- bus_busy  out  1  bus not free
- arbitration_lost  out  1  one-cycle pulse

## Operation
- Condition detect uses registered previous samples SDA_p and SCL_p (reset value 1).
  - START = SCL_sync & SCL_p & SDA_p & !SDA_sync.
  - STOP = SCL_sync & SCL_p & !SDA_p & SDA_sync.
  - SCL_rise = SCL_sync & !SCL_p.
- The FSM has four states: IDLE, MASTER, SLAVE, HOLDOFF. The reset state is IDLE.
- IDLE:
  - A START moves to SLAVE. This takes priority over ms_select=1 in the same cycle.
  - Otherwise, ms_select=1 with SDA_sync=SCL_sync=1 moves to MASTER.
  - Otherwise, stay in IDLE.
- MASTER:
  - STOP moves to HOLDOFF.
  - Arbitration loss moves to SLAVE. Loss is SCL_rise while SDA_out_master=1 and SDA_sync=0.
- SLAVE: STOP moves to HOLDOFF.
- HOLDOFF:
  - START moves to SLAVE.
  - Counter reaching BUS_FREE_CYCLES-1 with SDA_sync=SCL_sync=1 moves to IDLE.
  - The counter clears to 0 on any cycle where SDA_sync or SCL_sync is 0, and on entry.
- Owner is master in MASTER and slave in every other state.
  - master_enable = (state==MASTER).
  - slave_enable = !master_enable.
  - bus_busy = (state!=IDLE).
- ms_select changes outside IDLE are ignored until the next IDLE.
- Counter width is $clog2(BUS_FREE_CYCLES+1). It saturates and never wraps.

## Timing
- State, master_enable, slave_enable and bus_busy are registered. Each updates on the clk edge after the detecting sample.
- All muxed outputs (SDA_out, SCL_out, the four pulses, rx_data) are registered. They are driven from the owner selected by the current state, with 1-cycle latency.
- On arbitration loss:
  - arbitration_lost = 1 for exactly the cycle in which state first reads SLAVE.
  - SDA_out and SCL_out come from the slave starting that same cycle's registered update. Worst case, the master drives the bus 2 cycles after the losing edge.
- Reset values, while n_rst=1 and after it:
  - state IDLE and counter 0.
  - SDA_out=1, SCL_out=1.
  - All pulses 0, rx_data=0.
  - master_enable=0, slave_enable=1, bus_busy=0, arbitration_lost=0.
- Reset asserted mid-transaction returns all of the above in the same cycle, asynchronously. The pins are released.
- STOP and START in consecutive cycles (HOLDOFF then START) go to SLAVE. The hold-off is abandoned.

## Configuration
- I2C_ARB_LOSS_EN defined: arbitration-loss detection is active as described.
- Not defined:
  - The loss transition is removed and arbitration_lost is tied to 0.
  - MASTER leaves only on STOP.

## Structure
- Package i2c_arb_pkg:
  - typedef enum logic [1:0] arb_state_t {IDLE, MASTER, SLAVE, HOLDOFF}.
  - typedef enum logic owner_t {OWN_SLAVE, OWN_MASTER}.
  - Default constant I2C_BUS_FREE_CYCLES = 16.
- Sub-module i2c_bus_condition_detect: SDA_p/SCL_p registers plus the START, STOP and SCL_rise outputs. It is reusable by the inner engines.

## Test plan
- Reset then idle with ms_select=0 → bus_busy=0, SDA_out=SCL_out=1, slave_enable=1, master_enable=0.
- ms_select=1, lines high → MASTER on the next edge. SDA_out follows SDA_out_master one cycle later. STOP then 16 high cycles → bus_busy=0 at cycle 17.
- ms_select=0, external START then 0x0E address byte → SLAVE. Slave rx_data=0x0E and RX_write_enable appear on the outputs one cycle after the slave asserts them.
- MASTER, SDA_out_master=1 while SDA_sync is forced 0 across SCL rise → arbitration_lost single pulse, state SLAVE, master_enable=0. With I2C_ARB_LOSS_EN undefined: no pulse, stays MASTER.
- STOP, then START after 5 high cycles in HOLDOFF → SLAVE, bus_busy stays 1. ms_select=1 asserted with START in IDLE → SLAVE wins.
- n_rst=1 mid-byte in MASTER → SDA_out=SCL_out=1 immediately, state IDLE. After release, IDLE re-grants per ms_select.
